bios_loader: RTL and testbench

- Host-side initiator for the BIOS byte-command protocol.
- Streams a program image from a synchronous image ROM to a BIOS command port. For each image byte it emits address-set and WRITE commands, and optionally READ-back verifies the byte. It finishes by issuing BOOT.
- Sits between an on-board image ROM or debug bridge and the BIOS serial/stream input, replacing a PC-driven loader.

---
 rtl/bios_loader.sv | 199 +++++++++++++++++++
 tb/tb_bios_loader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bios_loader.sv
// Streams an image ROM to a BIOS command port: RST, then per byte ADR_UPPER/ADR_LOWER/WRITE (and READ-verify), then BOOT.
// Command bytes use valid/ready with o_data held while stalled; readback bytes are accepted only while awaiting them.
module bios_loader #(
  parameter int unsigned LEN_WIDTH = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter bit          VERIFY    = 1'b1,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [LEN_WIDTH-1:0] i_length,
  output logic [LEN_WIDTH-1:0] o_img_addr,
  input  logic [7:0]           i_img_data,
  output logic [7:0]           o_data,
  output logic                 o_valid,
  input  logic                 i_out_ready,
  input  logic [7:0]           i_data,
  input  logic                 i_valid,
  output logic                 o_in_ready,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error,
  output logic [31:0]          o_err_addr
);

  localparam logic [7:0]  OP_BOOT      = 8'h01;
  localparam logic [7:0]  OP_RST       = 8'h02;
  localparam logic [7:0]  OP_READ      = 8'h03;
  localparam logic [7:0]  OP_WRITE     = 8'h04;
  localparam logic [7:0]  OP_ADR_LOWER = 8'h05;
  localparam logic [7:0]  OP_ADR_UPPER = 8'h06;
  localparam logic [15:0] TIMER_LAST   = 16'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RST_OP, S_FETCH_A, S_FETCH_D, S_ADR_HI, S_ADR_LO, S_WR,
    S_RD_OP, S_RD_WAIT, S_NEXT, S_BOOT_OP, S_DONE, S_ERR
  } state_t;

  state_t                 state_q, state_d, send_next;
  logic [1:0]             cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]   idx_q, idx_d, len_q, len_d, idx_inc;
  logic [7:0]             byte_q, byte_d;
  logic [15:0]            timer_q, timer_d;
  logic                   busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [31:0]            err_addr_q, err_addr_d;
  logic [31:0]            addr;
  logic                   last, xfer;

  assign addr       = BASE_ADDR + 32'(idx_q);
  assign idx_inc    = idx_q + LEN_WIDTH'(1);
  assign o_img_addr = idx_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_error    = error_q;
  assign o_err_addr = err_addr_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    len_d      = len_q;
    byte_d     = byte_q;
    timer_d    = timer_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    err_addr_d = err_addr_q;
    o_valid    = 1'b0;
    o_data     = 8'h00;
    o_in_ready = 1'b0;
    last       = 1'b1;
    send_next  = state_q;

    // Byte presented depends only on registered state, so it cannot change while stalled.
    case (state_q)
      S_RST_OP: begin
        o_valid   = 1'b1;
        o_data    = OP_RST;
        send_next = (len_q == '0) ? S_BOOT_OP : S_FETCH_A;
      end
      S_ADR_HI: begin
        o_valid   = 1'b1;
        last      = (cnt_q == 2'd2);
        o_data    = (cnt_q == 2'd0) ? OP_ADR_UPPER :
                    (cnt_q == 2'd1) ? addr[23:16] : addr[31:24];
        send_next = S_ADR_LO;
      end
      S_ADR_LO: begin
        o_valid   = 1'b1;
        last      = (cnt_q == 2'd2);
        o_data    = (cnt_q == 2'd0) ? OP_ADR_LOWER :
                    (cnt_q == 2'd1) ? addr[7:0] : addr[15:8];
        send_next = S_WR;
      end
      S_WR: begin
        o_valid   = 1'b1;
        last      = (cnt_q == 2'd1);
        o_data    = (cnt_q == 2'd0) ? OP_WRITE : byte_q;
        send_next = VERIFY ? S_RD_OP : S_NEXT;
      end
      S_RD_OP: begin
        o_valid   = 1'b1;
        o_data    = OP_READ;
        send_next = S_RD_WAIT;
      end
      S_BOOT_OP: begin
        o_valid   = 1'b1;
        o_data    = OP_BOOT;
        send_next = S_DONE;
      end
      S_RD_WAIT: o_in_ready = 1'b1;
      default: ;
    endcase

    xfer = o_valid & i_out_ready;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          len_d   = i_length;
          idx_d   = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
          busy_d  = 1'b1;
          state_d = S_RST_OP;
        end
      end
      S_RST_OP, S_ADR_HI, S_ADR_LO, S_WR, S_RD_OP, S_BOOT_OP: begin
        timer_d = '0;
        if (xfer) begin
          if (last) begin
            cnt_d   = '0;
            state_d = send_next;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      S_FETCH_A: state_d = S_FETCH_D;
      S_FETCH_D: begin
        byte_d  = i_img_data;
        state_d = (idx_q == '0 || addr[15:0] == 16'h0000) ? S_ADR_HI : S_ADR_LO;
      end
      S_RD_WAIT: begin
        if ((i_valid && i_data != byte_q) || (!i_valid && timer_q == TIMER_LAST)) begin
          error_d    = 1'b1;
          err_addr_d = addr;
          state_d    = S_ERR;
        end else if (i_valid) begin
          state_d = S_NEXT;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      S_NEXT: begin
        idx_d   = idx_inc;
        state_d = (idx_inc == len_q) ? S_BOOT_OP : S_FETCH_A;
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_ERR: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      len_q      <= '0;
      byte_q     <= '0;
      timer_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      byte_q     <= byte_d;
      timer_q    <= timer_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_addr_q <= err_addr_d;
    end
  end

endmodule

// File: tb/tb_bios_loader.sv
// Two loaders (no-verify at 0x100, verify at 0xFFFE with a short timeout) checked against a byte-stream scoreboard.
module tb_bios_loader;
  localparam int          LW     = 16;
  localparam logic [31:0] BASE_A = 32'h0000_0100;
  localparam logic [31:0] BASE_B = 32'h0000_FFFE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start [2];
  logic [LW-1:0] length [2];
  logic [LW-1:0] img_addr [2];
  logic [7:0]    img_data [2];
  logic [7:0]    cmd [2];
  logic          valid [2];
  logic          out_ready [2];
  logic [7:0]    rd_data [2];
  logic          rd_valid [2];
  logic          in_ready [2];
  logic          busy [2];
  logic          done [2];
  logic          error [2];
  logic [31:0]   err_addr [2];
  logic [7:0]    rom [2][256];

  bios_loader #(.LEN_WIDTH(LW), .BASE_ADDR(BASE_A), .VERIFY(1'b0), .TIMEOUT(1024)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_start(start[0]), .i_length(length[0]),
    .o_img_addr(img_addr[0]), .i_img_data(img_data[0]), .o_data(cmd[0]), .o_valid(valid[0]),
    .i_out_ready(out_ready[0]), .i_data(rd_data[0]), .i_valid(rd_valid[0]), .o_in_ready(in_ready[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_error(error[0]), .o_err_addr(err_addr[0]));

  bios_loader #(.LEN_WIDTH(LW), .BASE_ADDR(BASE_B), .VERIFY(1'b1), .TIMEOUT(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_start(start[1]), .i_length(length[1]),
    .o_img_addr(img_addr[1]), .i_img_data(img_data[1]), .o_data(cmd[1]), .o_valid(valid[1]),
    .i_out_ready(out_ready[1]), .i_data(rd_data[1]), .i_valid(rd_valid[1]), .o_in_ready(in_ready[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_error(error[1]), .o_err_addr(err_addr[1]));

  always @(posedge clk) begin
    img_data[0] <= rom[0][img_addr[0][7:0]];
    img_data[1] <= rom[1][img_addr[1][7:0]];
  end

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  logic [7:0] exp_q [$];
  logic       rdy_rand [2];
  logic       hold_v [2];
  logic [7:0] hold_d [2];
  int         rd_idx, bad_idx, rd_delay;
  bit         resp_en, acc_prev;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Random backpressure, applied just after the rising edge.
  always @(posedge clk) begin
    #1;
    for (int g = 0; g < 2; g++)
      if (rdy_rand[g]) out_ready[g] = ($urandom_range(0, 99) < 60);
  end

  // BIOS echo model for the verifying loader; random junk whenever the loader is not listening.
  always @(negedge clk) begin
    if (acc_prev) begin
      rd_idx++;
      rd_delay = $urandom_range(0, 3);
    end
    if (in_ready[1] && resp_en) begin
      if (rd_delay == 0) begin
        rd_valid[1] = 1'b1;
        rd_data[1]  = rom[1][8'(rd_idx)] ^ ((rd_idx == bad_idx) ? 8'h11 : 8'h00);
      end else begin
        rd_valid[1] = 1'b0;
        rd_delay--;
      end
    end else if (in_ready[1]) begin
      rd_valid[1] = 1'b0;
    end else begin
      rd_valid[1] = ($urandom_range(0, 1) == 1);
      rd_data[1]  = 8'($urandom);
    end
    acc_prev    = rd_valid[1] && in_ready[1];
    rd_valid[0] = ($urandom_range(0, 1) == 1);
    rd_data[0]  = 8'($urandom);
  end

  // Monitor: every transferred byte is popped against the scoreboard; stalled bytes must hold.
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      hold_v[0] = 1'b0;
      hold_v[1] = 1'b0;
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (hold_v[g]) begin
          check("hold_valid", 32'(valid[g]), 32'd1);
          check("hold_data", 32'(cmd[g]), 32'(hold_d[g]));
        end
        hold_v[g] = valid[g] && !out_ready[g];
        hold_d[g] = cmd[g];
        if (valid[g] && out_ready[g]) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL extra_byte: loader %0d sent %0h, required no byte", g, cmd[g]);
          end else begin
            check("stream_byte", 32'(cmd[g]), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  // Reference: the command stream the protocol prescribes for an image, cut after the failing READ.
  task automatic push_model(input int g, input int len, input int stop);
    logic [31:0] a;
    exp_q.push_back(8'h02);
    for (int i = 0; i < len; i++) begin
      a = ((g == 0) ? BASE_A : BASE_B) + 32'(i);
      if (i == 0 || a[15:0] == 16'h0000) begin
        exp_q.push_back(8'h06); exp_q.push_back(a[23:16]); exp_q.push_back(a[31:24]);
      end
      exp_q.push_back(8'h05); exp_q.push_back(a[7:0]); exp_q.push_back(a[15:8]);
      exp_q.push_back(8'h04); exp_q.push_back(rom[g][i]);
      if (g == 1) begin
        exp_q.push_back(8'h03);
        if (i == stop) return;
      end
    end
    exp_q.push_back(8'h01);
  endtask

  task automatic start_load(input int g, input int len);
    @(negedge clk); #1;
    length[g] = 16'(len);
    start[g]  = 1'b1;
    @(posedge clk); #1;
    start[g] = 1'b0;
    check("start_busy", 32'(busy[g]), 32'd1);
    check("start_done_clr", 32'(done[g]), 32'd0);
    check("start_err_clr", 32'(error[g]), 32'd0);
  endtask

  task automatic wait_idle(input int g);
    int n = 0;
    while (busy[g] && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (busy[g]) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_wait: busy still 1 after %0d cycles, required 0", n);
    end
  endtask

  task automatic fill_rom(input int g, input int len);
    for (int i = 0; i < len; i++) rom[g][i] = 8'($urandom);
  endtask

  task automatic run_load(input int g, input int len, input int stop, input bit rnd, input bit poke);
    exp_q.delete();
    push_model(g, len, stop);
    rdy_rand[g] = rnd;
    if (!rnd) out_ready[g] = 1'b1;
    rd_idx = 0; rd_delay = 0; bad_idx = stop; resp_en = 1'b1;
    start_load(g, len);
    if (poke) begin
      repeat (10) @(negedge clk);
      #1;
      if (busy[g]) begin
        start[g] = 1'b1; length[g] = 16'd7;
        @(posedge clk); #1;
        start[g] = 1'b0;
      end
    end
    wait_idle(g);
    @(negedge clk); #1;
    check("end_done", 32'(done[g]), 32'(stop < 0));
    check("end_error", 32'(error[g]), 32'(stop >= 0));
    check("end_busy", 32'(busy[g]), 32'd0);
    if (stop >= 0) check("err_addr", err_addr[g], BASE_B + 32'(stop));
    check("stream_left", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    check("done_sticky", 32'(done[g]), 32'(stop < 0));
    check("error_sticky", 32'(error[g]), 32'(stop >= 0));
  endtask

  task automatic check_reset_outputs(input int g);
    check("rst_valid", 32'(valid[g]), 32'd0);
    check("rst_data", 32'(cmd[g]), 32'd0);
    check("rst_busy", 32'(busy[g]), 32'd0);
    check("rst_done", 32'(done[g]), 32'd0);
    check("rst_error", 32'(error[g]), 32'd0);
    check("rst_err_addr", err_addr[g], 32'd0);
    check("rst_img_addr", 32'(img_addr[g]), 32'd0);
    check("rst_in_ready", 32'(in_ready[g]), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t0, t1;
    for (int g = 0; g < 2; g++) begin
      start[g] = 1'b0; length[g] = '0; out_ready[g] = 1'b1; rdy_rand[g] = 1'b0;
      rd_valid[g] = 1'b0; rd_data[g] = 8'h00; hold_v[g] = 1'b0;
      for (int i = 0; i < 256; i++) rom[g][i] = 8'h00;
    end
    rd_idx = 0; bad_idx = -1; rd_delay = 0; resp_en = 1'b0; acc_prev = 1'b0;
    #3;
    check_reset_outputs(0);
    check_reset_outputs(1);
    #20 rst_n = 1'b1;

    // Fixed image, full-rate and then throttled, with a start pulse while busy.
    rom[0][0] = 8'hAA; rom[0][1] = 8'hBB; rom[0][2] = 8'hCC;
    run_load(0, 3, -1, 1'b0, 1'b0);
    run_load(0, 3, -1, 1'b1, 1'b1);
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 12);
      fill_rom(0, n);
      run_load(0, n, -1, 1'b1, 1'b0);
    end
    run_load(0, 0, -1, 1'b1, 1'b0);

    // Verifying loader: crosses the 64 KiB boundary, then mismatches at bytes 0 and 2.
    rom[1][0] = 8'hAA; rom[1][1] = 8'hBB; rom[1][2] = 8'hCC; rom[1][3] = 8'hDD;
    run_load(1, 4, -1, 1'b0, 1'b0);
    run_load(1, 3, 0, 1'b1, 1'b0);
    fill_rom(1, 5);
    run_load(1, 5, 2, 1'b1, 1'b0);
    for (int r = 0; r < 2; r++) begin
      n = $urandom_range(1, 8);
      fill_rom(1, n);
      run_load(1, n, -1, 1'b1, 1'b0);
    end

    // Timeout: no readback at all.
    fill_rom(1, 3);
    exp_q.delete();
    push_model(1, 3, 0);
    rdy_rand[1] = 1'b0; out_ready[1] = 1'b1; resp_en = 1'b0;
    start_load(1, 3);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!in_ready[1] && n < 200);
    t0 = cyc;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!error[1] && n < 200);
    t1 = cyc;
    check("timeout_cycles", 32'(t1 - t0), 32'd16);
    check("timeout_in_ready", 32'(in_ready[1]), 32'd0);
    check("timeout_err_addr", err_addr[1], BASE_B);
    wait_idle(1);
    @(negedge clk); #1;
    check("timeout_done", 32'(done[1]), 32'd0);
    check("timeout_left", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset while the WRITE opcode is stalled.
    rom[0][0] = 8'hAA; rom[0][1] = 8'hBB; rom[0][2] = 8'hCC;
    exp_q.delete();
    push_model(0, 3, -1);
    rdy_rand[0] = 1'b0; out_ready[0] = 1'b0;
    start_load(0, 3);
    for (int k = 0; k < 7; k++) begin
      n = 0;
      do begin @(negedge clk); #1; n++; end while (!valid[0] && n < 50);
      out_ready[0] = 1'b1;
      @(posedge clk); #1;
      out_ready[0] = 1'b0;
    end
    @(negedge clk); #1;
    check("wr_valid", 32'(valid[0]), 32'd1);
    check("wr_opcode", 32'(cmd[0]), 32'h04);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs(0);
    check_reset_outputs(1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    run_load(0, 3, -1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
